// File: rtl/exec_pkg.sv
// exec_pkg: opcode and FSM state encodings shared by the multiply/divide unit.
package exec_pkg;
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIV   = 2'b10,
        OP_REM   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: bit-serial datapath, one shift-add multiply or restoring divide step per cycle.
// Multiply: lo = multiplier, div = multiplicand. Divide: lo = |dividend| (becomes quotient), hi = partial remainder.
module muldiv_iter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         load_div,
    input  logic [W-1:0] load_lo,
    input  logic [W-1:0] load_d,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         last
);
    localparam int CW = $clog2(W);
    logic [W-1:0] d;
    logic [CW-1:0] cnt;
    logic is_div, ge;
    logic [W:0] sum, trial;
    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        trial = {hi, lo[W-1]} - {1'b0, d};
        ge    = !trial[W];
        last  = cnt == CW'(W - 1);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            d      <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
        end else if (load) begin
            hi     <= '0;
            lo     <= load_lo;
            d      <= load_d;
            cnt    <= '0;
            is_div <= load_div;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                hi <= ge ? trial[W-1:0] : {hi[W-2:0], lo[W-1]};
                lo <= {lo[W-2:0], ge};
            end else begin
                hi <= sum[W:1];
                lo <= {sum[0], lo[W-1:1]};
            end
        end
    end
endmodule

// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative MUL/MULHU/DIV/REM unit with W+1 cycle latency.
// Divide runs on magnitudes; signs and the divide-by-zero result are fixed up at the output.
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_start,
    input  logic [1:0]                 in_op,
    input  logic [IALU_WORD_WIDTH-1:0] in_src1,
    input  logic [IALU_WORD_WIDTH-1:0] in_src2,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_flush,
    output logic                       out_stall,
    output logic                       out_res_valid,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic                       out_div_by_zero
);
    localparam int W = IALU_WORD_WIDTH;
    state_t state, state_nx;
    op_t op;
    logic [REG_IDX_WIDTH-1:0] idx;
    logic neg_q, neg_r, dbz, accept, last, is_div, s1, s2;
    logic [W-1:0] hi, lo, q, r, res, load_lo, load_d;
    always_comb begin
        accept   = state != S_BUSY && in_start && !in_flush && !reset;
        state_nx = in_flush ? S_IDLE : accept ? S_BUSY :
                   state == S_BUSY ? (last ? S_DONE : S_BUSY) : S_IDLE;
        is_div   = is_div_op(in_op);
        s1       = is_div && in_src1[W-1];
        s2       = is_div && in_src2[W-1];
        load_lo  = is_div ? (s1 ? -in_src1 : in_src1) : in_src2;
        load_d   = is_div ? (s2 ? -in_src2 : in_src2) : in_src1;
        q        = dbz ? '1 : neg_q ? -lo : lo;
        r        = neg_r ? -hi : hi;
        res      = op == OP_MUL ? lo : op == OP_MULHU ? hi : op == OP_DIV ? q : r;
        out_stall       = state == S_BUSY || accept;
        out_res_valid   = state == S_DONE && !in_flush;
        out_res         = out_res_valid ? res : '0;
        out_res_reg_idx = out_res_valid ? idx : '0;
        out_div_by_zero = out_res_valid && dbz;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            op    <= OP_MUL;
            idx   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op    <= op_t'(in_op);
                idx   <= in_res_reg_idx;
                neg_q <= s1 ^ s2;
                neg_r <= s1;
                dbz   <= is_div && in_src2 == '0;
            end
        end
    end
    muldiv_iter #(.W(W)) u_iter (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .step     (state == S_BUSY),
        .load_div (is_div),
        .load_lo  (load_lo),
        .load_d   (load_d),
        .hi       (hi),
        .lo       (lo),
        .last     (last)
    );
endmodule

// File: tb/tb_exec_muldiv.sv
// tb_exec_muldiv: directed and randomized checks of exec_muldiv against an arithmetic reference model.
module tb_exec_muldiv;
    localparam int W = 16;
    localparam int LAT = W + 1;
    logic clock = 1'b0;
    logic reset, in_start, in_flush;
    logic [1:0] in_op;
    logic [W-1:0] in_src1, in_src2;
    logic [3:0] in_res_reg_idx;
    logic out_stall, out_res_valid, out_div_by_zero;
    logic [W-1:0] out_res;
    logic [3:0] out_res_reg_idx;
    int checks = 0;
    int failures = 0;

    exec_muldiv #(.IALU_WORD_WIDTH(W), .REG_IDX_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .in_start(in_start), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_res_reg_idx(in_res_reg_idx),
        .in_flush(in_flush), .out_stall(out_stall), .out_res_valid(out_res_valid),
        .out_res(out_res), .out_res_reg_idx(out_res_reg_idx), .out_div_by_zero(out_div_by_zero)
    );

    always #5 clock = ~clock;

    // Returns {div_by_zero, result}, from plain integer arithmetic.
    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        int sa, sb, v;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op == 2'd0) return {1'b0, p[W-1:0]};
        if (op == 2'd1) return {1'b0, p[2*W-1:W]};
        if (b == '0) return (op == 2'd2) ? {1'b1, {W{1'b1}}} : {1'b1, a};
        v = (op == 2'd2) ? sa / sb : sa % sb;
        return {1'b0, v[W-1:0]};
    endfunction

    // Issue one op and wait for its valid pulse; lat counts cycles after the accept cycle.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] idx, output logic st, output int lat,
                         output logic [W-1:0] res, output logic dz, output logic [3:0] ridx);
        @(negedge clock);
        in_start = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_res_reg_idx = idx;
        #1 st = out_stall;
        @(negedge clock);
        in_start = 1'b0;
        lat = 1;
        while (!out_res_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        res = out_res; dz = out_div_by_zero; ridx = out_res_reg_idx;
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic st, dz;
        int lat;
        logic [W-1:0] res;
        logic [3:0] ridx, idx;
        logic [W:0] exp;
        idx = 4'($urandom);
        exp = model(op, a, b);
        do_op(op, a, b, idx, st, lat, res, dz, ridx);
        checks++;
        if (st !== 1'b1 || lat !== LAT || res !== exp[W-1:0] || dz !== exp[W] || ridx !== idx) begin
            failures++;
            $display("FAIL %s op=%0d a=%h b=%h: got stall=%b lat=%0d res=%h dbz=%b idx=%h, want stall=1 lat=%0d res=%h dbz=%b idx=%h",
                     name, op, a, b, st, lat, res, dz, ridx, LAT, exp[W-1:0], exp[W], idx);
        end
        @(negedge clock);
        checks++;
        if (out_res_valid !== 1'b0 || out_res !== '0 || out_stall !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: valid=%b res=%h stall=%b, want 0 0 0", name, out_res_valid, out_res, out_stall);
        end
    endtask

    task automatic wait_quiet(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (out_res_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL %s: %0d valid pulses, want 0", name, seen);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_start = 1'b1; in_flush = 1'b0; in_op = 2'd0;
        in_src1 = 16'h1234; in_src2 = 16'h0010; in_res_reg_idx = 4'h5;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({out_stall, out_res_valid, out_res, out_res_reg_idx, out_div_by_zero} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: stall=%b valid=%b res=%h idx=%h dbz=%b, want all 0",
                     out_stall, out_res_valid, out_res, out_res_reg_idx, out_div_by_zero);
        end
        reset = 1'b0; in_start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed;
        check_op("mul", 2'd0, 16'h1234, 16'h0010);
        check_op("mulhu", 2'd1, 16'h1234, 16'h0010);
        check_op("div_neg", 2'd2, 16'h0007, 16'hFFFD);
        check_op("rem_pos", 2'd3, 16'h0007, 16'hFFFD);
        check_op("rem_neg", 2'd3, 16'hFFF9, 16'h0003);
        check_op("div_zero", 2'd2, 16'h0064, 16'h0000);
        check_op("rem_zero", 2'd3, 16'h0064, 16'h0000);
        check_op("rem_zero_neg", 2'd3, 16'hFF9C, 16'h0000);
        check_op("div_ovf", 2'd2, 16'h8000, 16'hFFFF);
        check_op("rem_ovf", 2'd3, 16'h8000, 16'hFFFF);
        check_op("mulhu_max", 2'd1, 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 9) == 0) begin a = 16'h8000; b = 16'hFFFF; end
            check_op("random", op, a, b);
        end
    endtask

    task automatic test_flush;
        @(negedge clock);
        in_start = 1'b1; in_op = 2'd0; in_src1 = 16'h0101; in_src2 = 16'h0202;
        @(negedge clock);
        in_start = 1'b0;
        repeat (4) @(negedge clock);
        in_flush = 1'b1; in_start = 1'b1;
        @(negedge clock);
        in_flush = 1'b0; in_start = 1'b0;
        #1;
        checks++;
        if (out_stall !== 1'b0 || out_res_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: stall=%b valid=%b, want 0 0", out_stall, out_res_valid);
        end
        wait_quiet("flush_no_pulse", 25);
        check_op("mul_after_flush", 2'd0, 16'd3, 16'd4);
    endtask

    task automatic test_flush_done;
        @(negedge clock);
        in_start = 1'b1; in_op = 2'd2; in_src1 = 16'd100; in_src2 = 16'd7;
        @(negedge clock);
        in_start = 1'b0;
        repeat (W) @(negedge clock);
        in_flush = 1'b1;
        #1;
        checks++;
        if (out_res_valid !== 1'b0 || out_res !== '0) begin
            failures++;
            $display("FAIL flush_done: valid=%b res=%h, want 0 0", out_res_valid, out_res);
        end
        @(negedge clock);
        in_flush = 1'b0;
        wait_quiet("flush_done_quiet", 20);
    endtask

    task automatic test_back_to_back;
        logic st, dz;
        int lat, gap;
        logic [W-1:0] res;
        logic [3:0] ridx;
        do_op(2'd0, 16'h1234, 16'h0010, 4'h3, st, lat, res, dz, ridx);
        checks++;
        if (lat !== LAT || res !== 16'h2340 || ridx !== 4'h3) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d res=%h idx=%h, want %0d 2340 3", lat, res, ridx, LAT);
        end
        in_start = 1'b1; in_op = 2'd3; in_src1 = 16'hFFF9; in_src2 = 16'h0003; in_res_reg_idx = 4'hA;
        #1;
        checks++;
        if (out_stall !== 1'b1 || out_res_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_in_done: stall=%b valid=%b, want 1 1", out_stall, out_res_valid);
        end
        @(negedge clock);
        in_start = 1'b0;
        gap = 1;
        while (!out_res_valid && gap < 40) begin
            @(negedge clock);
            gap++;
        end
        checks++;
        if (gap !== LAT || out_res !== 16'hFFFF || out_res_reg_idx !== 4'hA) begin
            failures++;
            $display("FAIL b2b_second: gap=%0d res=%h idx=%h, want %0d ffff a", gap, out_res, out_res_reg_idx, LAT);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        in_start = 1'b1; in_op = 2'd1; in_src1 = 16'hFFFF; in_src2 = 16'h00FF;
        @(negedge clock);
        in_start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({out_stall, out_res_valid, out_res, out_res_reg_idx, out_div_by_zero} !== '0) begin
            failures++;
            $display("FAIL reset_mid: stall=%b valid=%b res=%h idx=%h dbz=%b, want all 0",
                     out_stall, out_res_valid, out_res, out_res_reg_idx, out_div_by_zero);
        end
        wait_quiet("reset_mid_no_pulse", 25);
        check_op("mul_after_reset", 2'd0, 16'hBEEF, 16'h0003);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_flush_done();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
